train_section_controller: RTL and testbench

Parametrised block-section controller for the train layout: N debounced track sensors divide a line into N-1 sections. Per-section occupancy is tracked for either running direction, and an entry into an occupied section latches a fault. Train count, last sensor, direction and fault are shown on a multiplexed seven-segment display. It sits between the raw sensor pins and the board display, as the next generation of the fixed six-sensor top level.

---
 rtl/train_section_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_train_section_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/train_section_controller.sv
// Block-section controller: debounced track sensors drive per-section occupancy
// with conflict latching, plus a scanned seven-segment status display.
module train_section_controller #(
    parameter int N_SENSORS       = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int N_DIGITS        = 4,
    parameter int REFRESH_DIV     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SENSORS-1:0]         sensors,
    input  logic                         dir,
    input  logic                         fault_clr,
    output logic [N_SENSORS-2:0]         occ,
    output logic [$clog2(N_SENSORS)-1:0] train_count,
    output logic                         fault,
    output logic [N_DIGITS-1:0]          an,
    output logic [6:0]                   seg7
);
    localparam int NSEC = N_SENSORS - 1;
    localparam int TCW  = $clog2(N_SENSORS);
    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIW  = $clog2(N_DIGITS);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_SENSORS-1:0] sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [N_SENSORS-1:0] filt_d;
    logic [N_SENSORS-1:0] evt;
    logic [NSEC-1:0]      occ_q, occ_d;
    logic [NSEC-1:0]      set_vec, clr_vec;
    logic                 conflict;
    logic                 dir_q, dir_d;
    logic [3:0]           last_q, last_d;
    logic [TCW-1:0]       train_count_q, train_count_d;
    logic [RCW-1:0]       refresh_q, refresh_d;
    logic [DIW-1:0]       digit_q, digit_d;
    logic [N_DIGITS-1:0]  an_q, an_d;
    logic [6:0]           seg7_q, seg7_d;
    logic [3:0]           nib;
    logic                 blank;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
        end else begin
            sync1_q     <= sensors;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SENSORS; gi++) begin : g_debounce
            logic [DCW-1:0] cnt_q, cnt_d;
            logic           filt_nx;

            // Count consecutive disagreeing samples; any agreeing sample restarts.
            always_comb begin
                cnt_d   = '0;
                filt_nx = filt_q[gi];
                if (sync2_q[gi] != filt_q[gi]) begin
                    if (cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
                        filt_nx = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + DCW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign filt_d[gi] = filt_nx;
        end
    endgenerate

    assign evt = filt_q & ~filt_prev_q;

    generate
        for (gi = 0; gi < NSEC; gi++) begin : g_section
            assign set_vec[gi] = dir_q ? evt[gi+1] : evt[gi];
            assign clr_vec[gi] = dir_q ? evt[gi]   : evt[gi+1];
        end
    endgenerate

    // A clear of the same section in the same cycle cancels the conflict.
    assign conflict = |(set_vec & occ_q & ~clr_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (conflict) state_d = S_FAULT;
            S_FAULT: if (fault_clr && !conflict) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        fault = (state_q == S_FAULT);
    end

    always_comb begin
        occ_d  = occ_q;
        dir_d  = dir_q;
        last_d = last_q;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (evt[i]) last_d = 4'(i);
        end
        if (state_q == S_RUN) begin
            if (!conflict) occ_d = (occ_q | set_vec) & ~clr_vec;
            if (occ_q == '0 && evt == '0) dir_d = dir;
        end else if (fault_clr && !conflict) begin
            occ_d = '0;
        end
        train_count_d = '0;
        for (int i = 0; i < NSEC; i++) begin
            train_count_d = train_count_d + TCW'(occ_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q         <= '0;
            dir_q         <= 1'b0;
            last_q        <= '0;
            train_count_q <= '0;
        end else begin
            occ_q         <= occ_d;
            dir_q         <= dir_d;
            last_q        <= last_d;
            train_count_q <= train_count_d;
        end
    end

    always_comb begin
        refresh_d = refresh_q + RCW'(1);
        digit_d   = digit_q;
        if (refresh_q == RCW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = (digit_q == DIW'(N_DIGITS - 1)) ? '0 : digit_q + DIW'(1);
        end
    end

    // Glyph and enable are built from the upcoming digit index so both
    // registers switch on the same edge as the index itself.
    always_comb begin
        nib   = 4'h0;
        blank = 1'b1;
        if (digit_d == DIW'(0)) begin
            nib   = 4'(train_count_q);
            blank = 1'b0;
        end else if (digit_d == DIW'(1)) begin
            nib   = last_q;
            blank = 1'b0;
        end else if (digit_d == DIW'(2)) begin
            nib   = dir_q ? 4'hB : 4'hF;
            blank = 1'b0;
        end else if (digit_d == DIW'(3)) begin
            nib   = 4'hE;
            blank = !fault;
        end
        an_d   = ~(N_DIGITS'(1) << digit_d);
        seg7_d = blank ? 7'b1111111 : hex_glyph(nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            digit_q   <= '0;
            an_q      <= ~N_DIGITS'(1);
            seg7_q    <= 7'b1000000;
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            seg7_q    <= seg7_d;
        end
    end

    assign occ         = occ_q;
    assign train_count = train_count_q;
    assign an          = an_q;
    assign seg7        = seg7_q;

endmodule

// File: tb/tb_train_section_controller.sv
// Directed plus randomized checks of the section controller against a
// train-level occupancy model; a second instance covers the wider display.
module tb_train_section_controller;
    localparam int NA = 6;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst, dir, fault_clr;
    logic [5:0] sens_a;
    logic [4:0] occ_a;
    logic [2:0] train_count_a;
    logic       fault_a;
    logic [3:0] an_a;
    logic [6:0] seg7_a;

    logic [9:0] sens_b;
    logic       dir_b, fault_clr_b;
    logic [8:0] occ_b;
    logic [3:0] train_count_b;
    logic       fault_b;
    logic [5:0] an_b;
    logic [6:0] seg7_b;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_occ;
    bit         m_fault;
    bit         m_dir;
    int         m_last;

    always #5 clk = ~clk;

    train_section_controller #(.N_SENSORS(6), .DEBOUNCE_CYCLES(4), .N_DIGITS(4), .REFRESH_DIV(16)) dut_a (
        .clk(clk), .rst(rst), .sensors(sens_a), .dir(dir), .fault_clr(fault_clr),
        .occ(occ_a), .train_count(train_count_a), .fault(fault_a), .an(an_a), .seg7(seg7_a));

    train_section_controller #(.N_SENSORS(10), .DEBOUNCE_CYCLES(4), .N_DIGITS(6), .REFRESH_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .sensors(sens_b), .dir(dir_b), .fault_clr(fault_clr_b),
        .occ(occ_b), .train_count(train_count_b), .fault(fault_b), .an(an_b), .seg7(seg7_b));

    function automatic logic [6:0] hex7(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_digit(input bit inst_b, input int k, input logic [6:0] exp, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (inst_b ? (an_b === ~(6'd1 << k)) : (an_a === ~(4'd1 << k))) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_scan"}, 32'(found), 32'd1);
        if (found) chk(tag, 32'(inst_b ? seg7_b : seg7_a), 32'(exp));
    endtask

    task automatic check_all_a();
        chk("occ", 32'(occ_a), 32'(m_occ));
        chk("fault", 32'(fault_a), 32'(m_fault));
        chk("train_count", 32'(train_count_a), 32'($countones(m_occ)));
        check_digit(0, 0, hex7($countones(m_occ)), "digit0");
        check_digit(0, 1, hex7(m_last), "digit1");
        check_digit(0, 2, m_dir ? hex7(11) : hex7(15), "digit2");
        check_digit(0, 3, m_fault ? hex7(14) : 7'b1111111, "digit3");
    endtask

    // Train-level rules: each event enters one section and leaves the one behind it.
    task automatic model_event(input logic [5:0] mask);
        bit set_s [5];
        bit clr_s [5];
        bit conflict;
        conflict = 0;
        for (int i = 0; i < 5; i++) begin
            set_s[i] = 0;
            clr_s[i] = 0;
        end
        for (int s = 0; s < NA; s++) begin
            if (mask[s]) begin
                m_last = s;
                if (!m_dir) begin
                    if (s < NA - 1) set_s[s] = 1;
                    if (s > 0) clr_s[s-1] = 1;
                end else begin
                    if (s > 0) set_s[s-1] = 1;
                    if (s < NA - 1) clr_s[s] = 1;
                end
            end
        end
        if (!m_fault) begin
            for (int i = 0; i < 5; i++) begin
                if (set_s[i] && m_occ[i] && !clr_s[i]) conflict = 1;
            end
            if (conflict) m_fault = 1;
            else begin
                for (int i = 0; i < 5; i++) begin
                    if (clr_s[i]) m_occ[i] = 1'b0;
                    else if (set_s[i]) m_occ[i] = 1'b1;
                end
            end
            if (!m_fault && m_occ == 5'd0) m_dir = dir;
        end
    endtask

    task automatic pulse_a(input logic [5:0] mask, input int width, input bit lat);
        logic [4:0] old_occ;
        int         old_tc;
        old_occ = m_occ;
        old_tc  = $countones(m_occ);
        model_event(mask);
        sens_a = mask;
        for (int c = 1; c <= width + 12; c++) begin
            @(posedge clk); #1;
            if (c == width) sens_a = 6'd0;
            if (lat && c == 6) chk("occ_before_latency", 32'(occ_a), 32'(old_occ));
            if (lat && c == 7) begin
                chk("occ_at_latency", 32'(occ_a), 32'(m_occ));
                chk("train_count_lag", 32'(train_count_a), 32'(old_tc));
            end
            if (lat && c == 8) chk("train_count_after", 32'(train_count_a), 32'($countones(m_occ)));
        end
        $display("pulse mask=%b width=%0d occ=%b fault=%0d dir_q=%0d last=%0d",
                 mask, width, m_occ, m_fault, m_dir, m_last);
    endtask

    task automatic glitch_a(input logic [5:0] mask, input int width);
        sens_a = mask;
        for (int c = 1; c <= width + 12; c++) begin
            @(posedge clk); #1;
            if (c == width) sens_a = 6'd0;
        end
        $display("glitch mask=%b width=%0d occ=%b", mask, width, m_occ);
    endtask

    task automatic clr_a();
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        if (m_fault) begin
            m_fault = 0;
            m_occ   = 5'd0;
        end
        if (m_occ == 5'd0) m_dir = dir;
        chk("fault_clr_fault", 32'(fault_a), 32'(m_fault));
        chk("fault_clr_occ", 32'(occ_a), 32'(m_occ));
        repeat (4) @(posedge clk);
        #1;
        $display("fault_clr occ=%b fault=%0d", m_occ, m_fault);
    endtask

    task automatic set_dir(input bit v);
        dir = v;
        repeat (4) @(posedge clk);
        #1;
        if (!m_fault && m_occ == 5'd0) m_dir = dir;
        $display("dir=%0d dir_q=%0d occ=%b", v, m_dir, m_occ);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sens_a = 6'd0;
        sens_b = 10'd0;
        fault_clr = 1'b0;
        dir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_occ = 5'd0;
        m_fault = 0;
        m_dir = 0;
        m_last = 0;
    endtask

    initial begin
        int         act;
        int         d;
        logic [5:0] exp_an;
        logic [5:0] mask;
        dir_b = 1'b0;
        fault_clr_b = 1'b0;

        do_reset();
        chk("reset_occ", 32'(occ_a), 32'd0);
        chk("reset_fault", 32'(fault_a), 32'd0);
        chk("reset_train_count", 32'(train_count_a), 32'd0);
        chk("reset_an", 32'(an_a), 32'hE);
        chk("reset_seg7", 32'(seg7_a), 32'h40);
        $display("reset done");

        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            d = (k / 2) % 6;
            exp_an = ~(6'd1 << d);
            chk("scan_b_an", 32'(an_b), 32'(exp_an));
            if (d >= 4) chk("scan_b_blank", 32'(seg7_b), 32'h7F);
        end
        $display("scan of wide display checked over 24 cycles");

        check_all_a();
        pulse_a(6'b000001, 10, 1); check_all_a();
        pulse_a(6'b000010, 10, 1); check_all_a();
        pulse_a(6'b000100, 10, 1); check_all_a();
        glitch_a(6'b001000, 3);    check_all_a();
        pulse_a(6'b001000, 10, 1);
        pulse_a(6'b010000, 10, 1);
        pulse_a(6'b100000, 10, 1); check_all_a();
        pulse_a(6'b000001, 10, 1);
        pulse_a(6'b000001, 10, 1); check_all_a();
        clr_a();                   check_all_a();
        pulse_a(6'b000001, 10, 1);
        pulse_a(6'b000011, 10, 1); check_all_a();
        clr_a();                   check_all_a();
        set_dir(1);                check_all_a();
        pulse_a(6'b000100, 8, 1);
        pulse_a(6'b001000, 8, 1);
        pulse_a(6'b010000, 8, 1);
        pulse_a(6'b100000, 8, 1);  check_all_a();
        pulse_a(6'b100000, 8, 1);  check_all_a();

        sens_b = 10'h200;
        repeat (8) @(posedge clk);
        #1;
        sens_b = 10'd0;
        repeat (12) @(posedge clk);
        #1;
        chk("b_occ", 32'(occ_b), 32'd0);
        chk("b_fault", 32'(fault_b), 32'd0);
        check_digit(1, 1, hex7(9), "b_digit1");
        check_digit(1, 0, hex7(0), "b_digit0");
        check_digit(1, 4, 7'b1111111, "b_digit4");
        check_digit(1, 5, 7'b1111111, "b_digit5");
        $display("wide instance S9 event checked");

        for (int step = 0; step < 40; step++) begin
            act = int'($urandom_range(0, 9));
            if (act <= 5) begin
                mask = 6'(1 << $urandom_range(0, 5));
                pulse_a(mask, int'($urandom_range(DB, DB + 6)), 1);
            end else if (act == 6) begin
                mask = 6'($urandom_range(1, 63));
                pulse_a(mask, int'($urandom_range(DB, DB + 6)), 1);
            end else if (act == 7) begin
                mask = 6'(1 << $urandom_range(0, 5));
                glitch_a(mask, int'($urandom_range(1, DB - 1)));
            end else if (act == 8) begin
                set_dir(1'($urandom_range(0, 1)));
            end else begin
                clr_a();
            end
            check_all_a();
        end

        do_reset();
        pulse_a(6'b000001, 8, 0);
        pulse_a(6'b000001, 8, 0);
        chk("pre_reset_fault", 32'(fault_a), 32'(m_fault));
        sens_a = 6'b000010;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sens_a = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_occ = 5'd0;
        m_fault = 0;
        m_dir = 0;
        m_last = 0;
        chk("rst_in_fault_fault", 32'(fault_a), 32'd0);
        chk("rst_in_fault_occ", 32'(occ_a), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        check_all_a();
        $display("reset during fault and debounce checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
